// File: rtl/rtg_fetch_fifo.sv
// rtl/rtg_fetch_fifo.sv - SDRAM burst prefetch FIFO feeding the RTG pixel formatter
module rtg_fetch_fifo #(
    parameter int BURST_WORDS = 8,
    parameter int FIFO_DEPTH  = 32,
    parameter int LOW_WATER   = 8
) (
    input  logic        clk_114,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [25:0] baseaddr,
    output logic [25:0] a,
    output logic        req,
    input  logic        ack,
    output logic        pri,
    input  logic [15:0] d,
    input  logic        fill,
    input  logic        rdreq,
    output logic [15:0] q
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = $clog2(BURST_WORDS) + 1;
    localparam logic [CW-1:0] BURST_C     = CW'(BURST_WORDS);
    localparam logic [CW-1:0] LOW_C       = CW'(LOW_WATER);
    localparam logic [CW:0]   SPACE_LIMIT = (CW+1)'(FIFO_DEPTH - BURST_WORDS);
    localparam logic [FW-1:0] LAST_FILL   = FW'(BURST_WORDS - 1);
    localparam logic [25:0]   ADDR_STEP   = 26'(2 * BURST_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] reserved_q, reserved_d;
    logic [FW-1:0] fillcnt_q, fillcnt_d;
    logic [25:0]   addr_q, addr_d;
    logic [25:0]   a_q, a_d;
    logic          req_q, req_d;
    logic          pri_q, pri_d;
    logic [15:0]   q_q, q_d;
    logic [15:0]   mem_q [FIFO_DEPTH];

    logic          wr_en;
    logic          pop;
    logic [CW:0]   used;
    logic [PW-1:0] rd_ptr_nxt;
    logic [25:0]   addr_sum;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        reserved_d = reserved_q;
        fillcnt_d  = fillcnt_q;
        addr_d     = addr_q;
        a_d        = a_q;
        req_d      = req_q;
        q_d        = q_q;
        addr_sum   = addr_q + ADDR_STEP;
        wr_en      = (state_q == S_FILL) && fill;
        pop        = rdreq && (count_q != '0);
        used       = {1'b0, count_q} + {1'b0, reserved_q};
        rd_ptr_nxt = rd_ptr_q + PW'(1);
        pri_d      = enable && (count_q < LOW_C);

        case (state_q)
            S_IDLE: begin
                if (enable && (used <= SPACE_LIMIT)) begin
                    state_d = S_REQ;
                    a_d     = addr_q;
                    req_d   = 1'b1;
                end
            end
            S_REQ: begin
                if (ack) begin
                    state_d    = S_FILL;
                    req_d      = 1'b0;
                    reserved_d = reserved_q + BURST_C;
                    fillcnt_d  = '0;
                end
            end
            S_FILL: begin
                if (wr_en) begin
                    if (fillcnt_q == LAST_FILL) begin
                        state_d    = S_IDLE;
                        fillcnt_d  = '0;
                        reserved_d = '0;
                        addr_d     = {addr_sum[25:4], 4'b0000};
                    end else begin
                        fillcnt_d = fillcnt_q + FW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_nxt;
        end
        if (wr_en && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - CW'(1);
        end

        // q mirrors the head; a word landing in an empty FIFO is preloaded one edge later,
        // except when it lands on the same edge the last stored word is popped.
        if (pop) begin
            if (count_q > CW'(1)) begin
                q_d = mem_q[rd_ptr_nxt];
            end else if (wr_en) begin
                q_d = d;
            end
        end else if (count_q != '0) begin
            q_d = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk_114 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            reserved_q <= '0;
            fillcnt_q  <= '0;
            addr_q     <= baseaddr;
            a_q        <= '0;
            req_q      <= 1'b0;
            pri_q      <= 1'b0;
            q_q        <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            reserved_q <= reserved_d;
            fillcnt_q  <= fillcnt_d;
            addr_q     <= addr_d;
            a_q        <= a_d;
            req_q      <= req_d;
            pri_q      <= pri_d;
            q_q        <= q_d;
        end
    end

    always_ff @(posedge clk_114) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= d;
        end
    end

    assign a   = a_q;
    assign req = req_q;
    assign pri = pri_q;
    assign q   = q_q;
endmodule

// File: tb/tb_rtg_fetch_fifo.sv
// tb/tb_rtg_fetch_fifo.sv - randomized scoreboard bench for rtg_fetch_fifo
module tb_rtg_fetch_fifo;
    localparam int BW = 8;
    localparam int LW = 8;

    logic        clk_114 = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [25:0] baseaddr;
    logic [25:0] a;
    logic        req;
    logic        ack;
    logic        pri;
    logic [15:0] d;
    logic        fill;
    logic        rdreq;
    logic [15:0] q;

    rtg_fetch_fifo #(.BURST_WORDS(BW), .FIFO_DEPTH(32), .LOW_WATER(LW)) dut (
        .clk_114 (clk_114),
        .reset_n (reset_n),
        .enable  (enable),
        .baseaddr(baseaddr),
        .a       (a),
        .req     (req),
        .ack     (ack),
        .pri     (pri),
        .d       (d),
        .fill    (fill),
        .rdreq   (rdreq),
        .q       (q)
    );

    always #5 clk_114 = ~clk_114;

    typedef struct packed {
        logic [15:0] q;
        logic        pri;
    } exp_t;

    exp_t        exp_q[$];
    logic [25:0] exp_addr[$];
    logic [15:0] mq[$];
    logic [15:0] mqv = 16'h0;
    int          checks = 0;
    int          errors = 0;
    int          req_rises = 0;
    logic        prev_req = 1'b0;
    logic [25:0] last_a = 26'h0;
    int          bst = 0;
    int          rem = 0;
    int          bursts_done = 0;
    logic [25:0] cur_addr = 26'h0;
    logic [15:0] data_ctr = 16'h1000;
    bit          auto_ack = 1'b1;
    bit          seq_data = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic timeout_fail(input string name, input int limit);
        checks++;
        errors++;
        $display("FAIL %s: timeout after %0d cycles", name, limit);
    endtask

    always @(negedge clk_114) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("q", {16'h0, q}, {16'h0, e.q});
            chk("pri", {31'h0, pri}, {31'h0, e.pri});
        end
        if (req && !prev_req) begin
            req_rises++;
            last_a = a;
            if (exp_addr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL addr: unexpected request a=0x%0h", a);
            end else begin
                chk("addr", {6'h0, a}, {6'h0, exp_addr.pop_front()});
            end
        end
        prev_req = req;
    end

    // One clock of stimulus plus the reference-model update for that edge.
    task automatic cycle(input int pop_pct, input int fill_pct, input bit stray);
        bit   acc;
        bit   popd;
        int   old;
        exp_t e;
        ack   = 1'b0;
        fill  = 1'b0;
        rdreq = 1'b0;
        if (reset_n && bst == 0 && req && auto_ack && $urandom_range(0, 2) != 0) ack = 1'b1;
        if (bst == 2 && $urandom_range(1, 100) <= fill_pct) begin
            fill = 1'b1;
            d    = seq_data ? data_ctr : 16'($urandom);
        end else if (stray) begin
            fill = 1'b1;
            d    = 16'($urandom);
        end
        if ($urandom_range(1, 100) <= pop_pct) rdreq = 1'b1;
        @(posedge clk_114);
        if (!reset_n) begin
            e.q   = 16'h0;
            e.pri = 1'b0;
        end else begin
            old   = mq.size();
            e.pri = enable && (old < LW);
            acc   = fill && (bst == 2);
            popd  = rdreq && (old > 0);
            if (popd) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(d);
                data_ctr++;
                rem--;
                if (rem == 0) begin
                    bst = 0;
                    bursts_done++;
                end
            end
            if (popd) begin
                if (mq.size() > 0) mqv = mq[0];
            end else if (old > 0) begin
                mqv = mq[0];
            end
            e.q = mqv;
            if (ack) begin
                bst      = 2;
                rem      = BW;
                cur_addr = cur_addr + 26'(2 * BW);
                exp_addr.push_back(cur_addr);
            end
        end
        exp_q.push_back(e);
        #1;
    endtask

    task automatic do_reset(input logic [25:0] base, input int hold);
        @(negedge clk_114);
        #1;
        reset_n = 1'b0;
        ack     = 1'b0;
        fill    = 1'b0;
        rdreq   = 1'b0;
        mq.delete();
        exp_addr.delete();
        mqv         = 16'h0;
        bst         = 0;
        rem         = 0;
        bursts_done = 0;
        data_ctr    = 16'h1000;
        baseaddr    = base;
        repeat (hold) cycle(0, 0, 0);
        chk("rst_req", {31'h0, req}, 0);
        chk("rst_a", {6'h0, a}, 0);
        chk("rst_q", {16'h0, q}, 0);
        chk("rst_pri", {31'h0, pri}, 0);
        @(negedge clk_114);
        #1;
        reset_n  = 1'b1;
        cur_addr = base;
        exp_addr.push_back(base);
    endtask

    task automatic run_until_bursts(input int n, input int limit, input int pop_pct,
                                    input int fill_pct, input string name);
        int k;
        k = 0;
        while (bursts_done < n && k < limit) begin
            cycle(pop_pct, fill_pct, 1'b0);
            k++;
        end
        if (bursts_done < n) timeout_fail(name, limit);
    endtask

    initial begin
        int r0;
        int k;
        int pp;
        int fp;
        reset_n  = 1'b0;
        enable   = 1'b1;
        baseaddr = 26'h0;
        ack      = 1'b0;
        fill     = 1'b0;
        d        = 16'h0;
        rdreq    = 1'b0;

        // First burst and in-order readout
        do_reset(26'h0123450, 2);
        cycle(0, 100, 1'b0);
        chk("first_req", {31'h0, req}, 1);
        chk("first_a", {6'h0, a}, 32'h0123450);
        run_until_bursts(1, 100, 0, 100, "first_burst");
        auto_ack = 1'b0;
        repeat (3) cycle(0, 100, 1'b0);
        chk("first_q", {16'h0, q}, 32'h1000);
        chk("second_a", {6'h0, last_a}, 32'h0123460);
        chk("second_req_pending", {31'h0, req}, 1);
        for (int i = 0; i < 8; i++) begin
            cycle(100, 0, 1'b0);
            chk("pop_seq", {16'h0, q}, (i < 7) ? 32'h1001 + 32'(i) : 32'h1007);
        end
        cycle(100, 0, 1'b0);
        chk("underflow_hold", {16'h0, q}, 32'h1007);
        chk("empty_pri", {31'h0, pri}, 1);

        // Backpressure: four bursts fill the FIFO, a fifth needs eight pops
        auto_ack = 1'b1;
        do_reset(26'h0200000, 2);
        r0 = req_rises;
        run_until_bursts(4, 400, 0, 100, "fill_to_full");
        repeat (20) cycle(0, 100, 1'b0);
        chk("full_rises", 32'(req_rises - r0), 4);
        chk("full_no_req", {31'h0, req}, 0);
        chk("full_pri", {31'h0, pri}, 0);
        repeat (8) cycle(100, 0, 1'b0);
        chk("no_req_before_8_pops", 32'(req_rises - r0), 4);
        repeat (40) cycle(0, 100, 1'b0);
        chk("one_more_req", 32'(req_rises - r0), 5);
        chk("refill_bursts", 32'(bursts_done), 5);

        // Reset in the middle of a burst, then stray fill words
        do_reset(26'h0555550, 2);
        k = 0;
        while (!(bst == 2 && rem == 5) && k < 100) begin
            cycle(0, 100, 1'b0);
            k++;
        end
        if (!(bst == 2 && rem == 5)) timeout_fail("mid_burst", 100);
        do_reset(26'h0ABCDE0, 2);
        auto_ack = 1'b0;
        repeat (5) cycle(0, 0, 1'b1);
        chk("stray_q", {16'h0, q}, 0);
        chk("stray_pri", {31'h0, pri}, 1);
        chk("stray_req", {31'h0, req}, 1);
        chk("stray_a", {6'h0, a}, 32'h0ABCDE0);
        auto_ack = 1'b1;
        run_until_bursts(1, 100, 0, 100, "after_stray");
        repeat (3) cycle(0, 0, 1'b0);
        chk("after_stray_q", {16'h0, q}, 32'h1000);

        // Address wrap at the top of the 26-bit space
        do_reset(26'h3FFFFF0, 2);
        r0 = req_rises;
        run_until_bursts(1, 100, 50, 100, "wrap_first");
        k = 0;
        while ((req_rises - r0) < 2 && k < 50) begin
            cycle(50, 100, 1'b0);
            k++;
        end
        if ((req_rises - r0) < 2) timeout_fail("wrap_second", 50);
        chk("wrap_a", {6'h0, last_a}, 0);

        // pri is forced low while disabled
        enable = 1'b0;
        repeat (3) cycle(100, 100, 1'b0);
        chk("pri_disabled", {31'h0, pri}, 0);
        enable = 1'b1;

        // Randomized traffic with random data, enable toggling and one reset
        seq_data = 1'b0;
        for (int seg = 0; seg < 12; seg++) begin
            if (seg == 6) do_reset(26'($urandom) & 26'h3FFFFF0, $urandom_range(1, 3));
            pp = $urandom_range(0, 100);
            fp = $urandom_range(30, 100);
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 19) == 0) enable = ~enable;
                cycle(pp, fp, 1'b0);
            end
        end

        repeat (2) cycle(0, 0, 1'b0);
        @(negedge clk_114);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rtg_fetch_fifo.md
# rtg_fetch_fifo

Prefetching SDRAM read stream for the RTG display path. It fetches 8-word bursts from a linear framebuffer, starting at a programmable base address, into a 32×16-bit FIFO, and presents words to the display pipeline one per `rdreq` strobe. It sits between the SDRAM controller's video port and the RTG pixel formatter. The parent holds it in reset through each vertical blank, so every frame restarts at `baseaddr`.

## Interface
Parameters:
- `BURST_WORDS`, 8: 16-bit words per SDRAM burst; power of two.
- `FIFO_DEPTH`, 32: FIFO capacity in words; power of two, at least 2×`BURST_WORDS`.
- `LOW_WATER`, 8: `pri` asserts while the stored word count is below this value.

Ports:
- `clk_114` in 1: sole clock; all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: permits new burst requests.
- `baseaddr` in 26: byte address of the first word; bits [3:0] are zero.
- `a` out 26: burst byte address, valid while `req` is high.
- `req` out 1: burst request.
- `ack` in 1: one-cycle grant from the SDRAM controller.
- `pri` out 1: urgent-priority hint to the arbiter.
- `d` in 16: read data from SDRAM.
- `fill` in 1: `d` is valid this cycle.
- `rdreq` in 1: pop the head word.
- `q` out 16: registered head word.

## Operation
- **State machine:** IDLE, REQ, FILL.
- **IDLE → REQ:** taken when `enable` is high and `FIFO_DEPTH − count ≥ BURST_WORDS`. The transition loads `a` from `addr` and sets `req`.
- **REQ:** hold `req` and `a` stable until `ack`. On `ack`, clear `req`, add `BURST_WORDS` to `reserved`, and go to FILL.
- **FILL:** each `fill` cycle writes `d` at the write pointer and increments `fillcnt`.
  - After the `BURST_WORDS`-th word: `addr ← addr + 2×BURST_WORDS` (modulo 2^26, with bits [3:0] forced to 0), `reserved ← 0`, go to IDLE.
  - `fill` words beyond `BURST_WORDS`, or arriving in IDLE or REQ, are discarded.
- **Occupancy:** `count` is the number of stored words; the space test uses `count + reserved`. By construction the FIFO never overflows.
- **Pop:** `rdreq` with `count > 0` advances the read pointer. The word then at the head is loaded into `q` on the same edge.
- **Simultaneous write and pop:** `count` is unchanged.
- **Underflow:** `rdreq` with `count = 0` is ignored; `q` holds its previous value and the pointers do not move.
- **`enable` low:**
  - No new request is issued.
  - Before `ack`, REQ stays pending (the request is not withdrawn).
  - A burst already in FILL completes normally.
  - `rdreq` still pops.
- **`pri`:** registered; equals `enable & (count < LOW_WATER)`.
- **Reset (async, including mid-burst):**
  - `req = 0`, `pri = 0`, `a = 0`, `q = 0`.
  - Pointers, `count`, `reserved` and `fillcnt` are cleared; state goes to IDLE.
  - `addr ← baseaddr`, sampled continuously while in reset.
  - Late `fill` words from the aborted burst are discarded because the state is IDLE.

## Timing
- **First request:** with `enable` high, `req` rises on the first rising edge after `reset_n` deasserts.
- **`ack`:** may arrive in any cycle after `req` rises, including the next one. `req` is low in the cycle after `ack`.
- **`fill`:** the first `fill` is no earlier than the cycle after `ack`. The burst need not be contiguous.
- **Write to visible:** a word written on edge N into an empty FIFO appears on `q` after edge N+1 (head preload). Thereafter each `rdreq` at edge M presents the next word after edge M.
- **Next request:** may issue in the cycle after the last fill word is written, if space allows.
- **Throughput:** one pop per cycle is sustainable while `count > 0`.

## Test plan
- **First burst:** `baseaddr` = 0x0123450, `enable` = 1, release reset → `req` = 1 and `a` = 0x0123450 next cycle. After `ack` and 8 fill words 0x1000–0x1007, the next request has `a` = 0x0123460 and `q` = 0x1000.
- **Read order:** pop 8 times at 1 per cycle → `q` sequence is 0x1001…0x1007. After that, `count` = 0 and a further `rdreq` leaves `q` at 0x1007.
- **Backpressure:** with no `rdreq`, the FIFO fills to 32 words. No fifth `req` is issued until 8 pops, after which exactly one `req` follows.
- **Reset mid-burst:** assert `reset_n` = 0 after 3 of 8 fill words, release, then feed 5 stray fill words → `count` = 0. The new `req` has `a` = the current `baseaddr`.
- **Address wrap:** `baseaddr` = 0x3FFFFF0 → the second burst address is 0x0000000.
- **`pri`:** `pri` is high at `count` 0–7, low at 8 or more, and low whenever `enable` = 0.
